// File: rtl/ray_hit_scoreboard.sv
// Hit/miss scoreboard: delays golden results by the core latency and counts
// type1 (golden hit, core miss), type2 (golden miss, core hit) and matches.
module ray_hit_lane (
   input  logic golden,
   input  logic hit_miss,
   output logic type1,
   output logic type2
);
   assign type1 = golden & ~hit_miss;
   assign type2 = ~golden & hit_miss;
endmodule

module ray_hit_scoreboard #(
   parameter int LANES   = 1,
   parameter int LATENCY = 34,
   parameter int CNT_W   = 16,
   parameter int NRAY_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NRAY_W-1:0] n_rays,
   input  logic              issue_vld,
   input  logic [LANES-1:0]  golden,
   input  logic [LANES-1:0]  hit_miss,
   output logic [CNT_W-1:0]  type1_cnt,
   output logic [CNT_W-1:0]  type2_cnt,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              sat,
   output logic              busy,
   output logic              done
);
   localparam int SW = $clog2(LANES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                         state;
   logic [NRAY_W-1:0]              nr;
   logic [NRAY_W-1:0]              issued;
   logic [LATENCY-1:0]             vld_pipe;
   logic [LATENCY-1:0][LANES-1:0]  gold_pipe;
   logic                           push;
   logic                           tail_vld;
   logic                           pending;
   logic [LANES-1:0]               e1, e2;
   logic [SW-1:0]                  t1_sum, t2_sum, m_sum;
   logic [CNT_W:0]                 s1, s2, sm;

   assign push     = issue_vld && (state == RUN) && (issued < nr);
   assign tail_vld = vld_pipe[LATENCY-1];
   // Anything still in flight once the tail entry has been consumed this cycle.
   assign pending  = |(vld_pipe << 1);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ray_hit_lane u_lane (
         .golden   (gold_pipe[LATENCY-1][i]),
         .hit_miss (hit_miss[i]),
         .type1    (e1[i]),
         .type2    (e2[i])
      );
   end

   always_comb begin
      t1_sum = '0;
      t2_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         t1_sum = t1_sum + SW'(e1[i]);
         t2_sum = t2_sum + SW'(e2[i]);
      end
      m_sum = SW'(LANES) - t1_sum - t2_sum;
   end

   assign s1 = {1'b0, type1_cnt} + (CNT_W+1)'(t1_sum);
   assign s2 = {1'b0, type2_cnt} + (CNT_W+1)'(t2_sum);
   assign sm = {1'b0, match_cnt} + (CNT_W+1)'(m_sum);

   // Golden payload needs no reset; only the valid bits qualify it.
   always_ff @(posedge clk)
      gold_pipe <= (gold_pipe << LANES) | (LATENCY*LANES)'(golden);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         nr        <= '0;
         issued    <= '0;
         vld_pipe  <= '0;
         type1_cnt <= '0;
         type2_cnt <= '0;
         match_cnt <= '0;
         sat       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         vld_pipe <= (vld_pipe << 1) | LATENCY'(push);
         if (push) issued <= issued + NRAY_W'(1);
         if (tail_vld) begin
            type1_cnt <= s1[CNT_W] ? '1 : s1[CNT_W-1:0];
            type2_cnt <= s2[CNT_W] ? '1 : s2[CNT_W-1:0];
            match_cnt <= sm[CNT_W] ? '1 : sm[CNT_W-1:0];
            if (s1[CNT_W] || s2[CNT_W] || sm[CNT_W]) sat <= 1'b1;
         end
         case (state)
            IDLE, DONE: if (start) begin
               nr        <= n_rays;
               issued    <= '0;
               type1_cnt <= '0;
               type2_cnt <= '0;
               match_cnt <= '0;
               sat       <= 1'b0;
               if (n_rays != '0) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            RUN: if (issued == nr) state <= DRAIN;
            DRAIN: if (!pending) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
